// File: rtl/xsr_pkg.sv
// xsr_pkg: parity mode constants, queue-entry field offsets and frame length helper
package xsr_pkg;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  // entry fields sit directly above the DATA_W-bit data field
  localparam int ENT_PERR = 0;
  localparam int ENT_FERR = 1;
  localparam int ENT_BRK  = 2;
  function automatic logic par_en(input logic [1:0] par);
    return par == PAR_ODD || par == PAR_EVEN;
  endfunction
  function automatic logic [6:0] frame_len(input logic [3:0] dbits, input logic [1:0] par);
    return 7'(dbits) + 7'(par_en(par)) + 7'd2;
  endfunction
endpackage

// File: rtl/xsr_rxq_fifo.sv
// xsr_rxq_fifo: synchronous FIFO with wrap-around pointers and a registered head entry
//   clk_i, reset_ni : clock, synchronous active-low reset
//   push, din       : write din (caller guarantees not full, or popping)
//   pop             : drop the head entry (caller guarantees not empty)
//   dout            : registered head entry
//   full, empty     : occupancy flags; count : occupancy 0..DEPTH
module xsr_rxq_fifo #(
  parameter int W = 10,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp, rp_n;
  assign rp_n = rp + {{AW{1'b0}}, pop};
  assign count = wp - rp;
  assign full = count[AW];
  assign empty = wp == rp;
  always_ff @(posedge clk_i)
    if (push) mem[wp[AW-1:0]] <= din;
  // the next head is either already stored or is the entry arriving this cycle
  always_ff @(posedge clk_i)
    if (!reset_ni) begin
      wp <= '0;
      rp <= '0;
      dout <= '0;
    end else begin
      wp <= wp + {{AW{1'b0}}, push};
      rp <= rp_n;
      if (push || pop) dout <= (push && wp == rp_n) ? din : mem[rp_n[AW-1:0]];
    end
endmodule

// File: rtl/xsr_rxq.sv
// xsr_rxq: decode characters captured from xsr on each idle rising edge and queue them
//   clk_i, reset_ni        : clock, synchronous active-low reset
//   idle_i, sr_i           : xsr idle flag and 64-bit receive shift register (newest bit at [63])
//   dbits_i, par_i         : data bits (clamped to 5..DATA_W) and parity mode, sampled at the strobe
//   dat_o/perr_o/ferr_o/brk_o, valid_o, ready_i : head entry and valid/ready pop port
//   count_o, ovr_o, ovr_clr_i : occupancy, sticky overrun and its clear
//   XSR_RXQ_BREAK_EN       : when defined, all-zero frames are flagged as break
module xsr_rxq
  import xsr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              idle_i,
  input  logic [63:0]       sr_i,
  input  logic [3:0]        dbits_i,
  input  logic [1:0]        par_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              perr_o,
  output logic              ferr_o,
  output logic              brk_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CW-1:0]     count_o,
  output logic              ovr_o,
  input  logic              ovr_clr_i
);
`ifdef XSR_RXQ_BREAK_EN
  localparam int EW = DATA_W + 3;
`else
  localparam int EW = DATA_W + 2;
`endif
  logic idle_q, stb, pop, push, full, empty, x, p, perr, ferr;
  logic [3:0] d;
  logic [6:0] b;
  logic [DATA_W-1:0] data;
  logic [EW-1:0] ent, head;
  assign stb = idle_i & ~idle_q;
  assign d = dbits_i < 4'd5 ? 4'd5 : dbits_i > 4'(DATA_W) ? 4'(DATA_W) : dbits_i;
  assign b = 7'd64 - frame_len(d, par_i);
  assign data = DATA_W'(sr_i >> (b + 7'd1)) & ~({DATA_W{1'b1}} << d);
  // the parity bit follows the data, so it lands at 63 - par_en
  assign p = sr_i[6'(b + 7'd1 + 7'(d))];
  assign x = ^data ^ p;
  assign perr = par_en(par_i) & (par_i == PAR_ODD ? ~x : x);
  assign ferr = sr_i[b[5:0]] | ~sr_i[63];
`ifdef XSR_RXQ_BREAK_EN
  assign ent = {(sr_i >> b) == 64'd0, ferr, perr, data};
  assign brk_o = head[DATA_W+ENT_BRK];
`else
  assign ent = {ferr, perr, data};
  assign brk_o = 1'b0;
`endif
  assign dat_o = head[DATA_W-1:0];
  assign perr_o = head[DATA_W+ENT_PERR];
  assign ferr_o = head[DATA_W+ENT_FERR];
  assign valid_o = ~empty;
  assign pop = valid_o & ready_i;
  assign push = stb & (~full | pop);
  xsr_rxq_fifo #(.W(EW), .DEPTH(DEPTH)) fifo (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .push(push),
    .pop(pop),
    .din(ent),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count_o)
  );
  always_ff @(posedge clk_i)
    if (!reset_ni) begin
      idle_q <= 1'b1;
      ovr_o <= 1'b0;
    end else begin
      idle_q <= idle_i;
      ovr_o <= (stb & ~push) | (ovr_o & ~ovr_clr_i);
    end
endmodule

// File: tb/tb_xsr_rxq.sv
// tb_xsr_rxq: randomized frames against a queue-based reference of the receive queue
module tb_xsr_rxq;
  localparam int DW = 8;
  localparam int DP = 16;
`ifdef XSR_RXQ_BREAK_EN
  localparam logic BRK = 1'b1;
`else
  localparam logic BRK = 1'b0;
`endif
  logic clk = 0, reset_ni = 0, idle_i = 1, ready_i = 0, ovr_clr_i = 0;
  logic [63:0] sr_i = '1;
  logic [3:0] dbits_i = 4'd8;
  logic [1:0] par_i = 2'd1;
  logic [DW-1:0] dat_o;
  logic perr_o, ferr_o, brk_o, valid_o, ovr_o;
  logic [4:0] count_o;
  int n_cmp = 0, n_bad = 0;
  logic [10:0] q[$];
  logic ovr_m = 0;
  logic [63:0] f85;
  logic [63:0] rs;
  logic [3:0] rd;
  logic [1:0] rp;
  logic [10:0] re;
  always #5 clk = ~clk;
  xsr_rxq #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .idle_i(idle_i), .sr_i(sr_i), .dbits_i(dbits_i),
    .par_i(par_i), .dat_o(dat_o), .perr_o(perr_o), .ferr_o(ferr_o), .brk_o(brk_o),
    .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o), .ovr_o(ovr_o), .ovr_clr_i(ovr_clr_i)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [10:0] head();
    return {brk_o, ferr_o, perr_o, dat_o};
  endfunction
  task automatic state(input string tag);
    check({tag, "_count"}, count_o, q.size());
    check({tag, "_valid"}, valid_o, q.size() != 0);
    check({tag, "_ovr"}, ovr_o, ovr_m);
    if (q.size() != 0) check({tag, "_head"}, head(), q[0]);
  endtask
  // one idle falling/rising pair; the strobe cycle optionally pops and/or clears overrun
  task automatic strobe(input logic [63:0] sr, input logic [3:0] db, input logic [1:0] pr,
                        input logic [10:0] exp, input logic pop_now, input logic clr);
    logic popped, dropped;
    ready_i = 0;
    idle_i = 0;
    tick;
    sr_i = sr; dbits_i = db; par_i = pr; idle_i = 1; ready_i = pop_now; ovr_clr_i = clr;
    popped = pop_now && q.size() > 0;
    dropped = q.size() == DP && !popped;
    if (popped) check("pop_head", head(), q[0]);
    tick;
    ready_i = 0; ovr_clr_i = 0;
    dbits_i = 4'($urandom); par_i = 2'($urandom); sr_i = {$urandom, $urandom};
    if (popped) void'(q.pop_front());
    if (!dropped) q.push_back(exp);
    ovr_m = dropped ? 1'b1 : clr ? 1'b0 : ovr_m;
  endtask
  // build a frame from its fields and derive the expected entry from the character rules
  task automatic rand_frame(output logic [63:0] sr, output logic [3:0] db, output logic [1:0] pr,
                            output logic [10:0] exp);
    int d, len;
    logic pe, zero, st, sp, p, perr, brk;
    logic [7:0] dat;
    db = 4'($urandom_range(0, 15));
    pr = 2'($urandom);
    d = db < 5 ? 5 : db > DW ? DW : int'(db);
    pe = pr == 2'd1 || pr == 2'd2;
    zero = $urandom % 8 == 0;
    dat = zero ? 8'h00 : 8'($urandom) & 8'((1 << d) - 1);
    st = zero ? 1'b0 : $urandom % 5 == 0;
    sp = zero ? 1'b0 : $urandom % 5 != 0;
    p = (pr == 2'd1) ? ~^dat : ^dat;
    if (zero) p = 1'b0;
    else if ($urandom % 4 == 0) p = ~p;
    len = d + 2 + int'(pe);
    sr = {$urandom, $urandom};
    sr[64-len] = st;
    for (int i = 0; i < d; i++) sr[65-len+i] = dat[i];
    if (pe) sr[65-len+d] = p;
    sr[63] = sp;
    perr = pe && ((^dat ^ p) != (pr == 2'd1));
    brk = BRK && !st && !sp && dat == 0 && (!pe || !p);
    exp = {brk, st | ~sp, perr, dat};
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 400 && q.size() > 0; i++) begin
      state(tag);
      ready_i = 1'($urandom);
      tick;
      if (ready_i) void'(q.pop_front());
      ready_i = 0;
    end
    check({tag, "_drained"}, q.size(), 0);
    state({tag, "_end"});
  endtask
  initial begin
    f85 = {11'b10100001010, {53{1'b1}}};
    tick;
    tick;
    check("rst_valid", valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_ovr", ovr_o, 0);
    check("rst_head", head(), 0);
    reset_ni = 1;
    tick;
    tick;
    check("rst_no_stb_valid", valid_o, 0);
    check("rst_no_stb_count", count_o, 0);
    strobe(f85, 4'd8, 2'd1, {3'b000, 8'h85}, 0, 0);
    check("8o1_valid", valid_o, 1);
    check("8o1_dat", dat_o, 8'h85);
    check("8o1_perr", perr_o, 0);
    check("8o1_ferr", ferr_o, 0);
    check("8o1_count", count_o, 1);
    strobe(f85, 4'd8, 2'd2, {3'b001, 8'h85}, 0, 0);
    strobe(f85 & ~(64'd1 << 63), 4'd8, 2'd1, {3'b010, 8'h85}, 0, 0);
    strobe(f85 | (64'd1 << 53), 4'd8, 2'd1, {3'b010, 8'h85}, 0, 0);
    strobe({7'b1101100, {57{1'b1}}}, 4'd5, 2'd0, {3'b000, 8'h16}, 0, 0);
    strobe(64'd0, 4'd8, 2'd1, {BRK, 2'b11, 8'h00}, 0, 0);
    state("directed");
    drain("directed");
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) begin
        rand_frame(rs, rd, rp, re);
        strobe(rs, rd, rp, re, 1'($urandom % 4 == 0), 0);
        state("rand_push");
      end
      drain("rand");
    end
    for (int k = 0; k <= DP; k++) begin
      rand_frame(rs, rd, rp, re);
      strobe(rs, rd, rp, re, 0, 0);
    end
    check("full_count", count_o, DP);
    check("full_ovr", ovr_o, 1);
    state("full");
    rand_frame(rs, rd, rp, re);
    strobe(rs, rd, rp, re, 1, 0);
    check("full_pushpop_count", count_o, DP);
    check("full_pushpop_ovr", ovr_o, 1);
    state("full_pushpop");
    rand_frame(rs, rd, rp, re);
    strobe(rs, rd, rp, re, 0, 1);
    check("ovr_set_beats_clr", ovr_o, 1);
    ovr_clr_i = 1;
    tick;
    ovr_clr_i = 0;
    ovr_m = 0;
    check("ovr_clr", ovr_o, 0);
    drain("full_drain");
    for (int k = 0; k <= DP; k++) begin
      rand_frame(rs, rd, rp, re);
      strobe(rs, rd, rp, re, 0, 0);
    end
    for (int k = 0; k < 3; k++) begin
      ready_i = 1;
      tick;
      void'(q.pop_front());
    end
    state("mid_drain");
    idle_i = 0;
    tick;
    idle_i = 1;
    ovr_clr_i = 0;
    reset_ni = 0;
    tick;
    ready_i = 0;
    reset_ni = 1;
    q.delete();
    ovr_m = 0;
    check("rst_mid_valid", valid_o, 0);
    check("rst_mid_count", count_o, 0);
    check("rst_mid_ovr", ovr_o, 0);
    tick;
    check("rst_mid_no_stb", valid_o, 0);
    strobe(f85, 4'd8, 2'd1, {3'b000, 8'h85}, 0, 0);
    state("post_rst");
    drain("post_rst");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
